// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bundle used on both sides of the arbiter.
// N is the number of ports sharing the bundle: request signals are packed per port,
// while read data and responses are single shared buses.
// The master modport drives requests; the slave modport answers them.
interface axi_lite_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [N-1:0]        ar_valid;
  logic [N-1:0]        ar_ready;
  logic [N*ADDR_W-1:0] ar_addr;
  logic [N-1:0]        r_valid;
  logic [N-1:0]        r_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic [N-1:0]        aw_valid;
  logic [N-1:0]        aw_ready;
  logic [N*ADDR_W-1:0] aw_addr;
  logic [N-1:0]        w_valid;
  logic [N-1:0]        w_ready;
  logic [N*DATA_W-1:0] w_data;
  logic [N*STRB_W-1:0] w_strb;
  logic [N-1:0]        b_valid;
  logic [N-1:0]        b_ready;
  logic [1:0]          b_resp;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter.
// Reads and writes are arbitrated independently, round-robin, one transaction
// outstanding per channel. Slave-side signals are steered combinationally from the
// registered grant, so apart from the one arbitration cycle there is no added latency.
module axi_lite_arbiter #(
  parameter int NUM_MST = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic clk,
  input  logic rst,
  axi_lite_arbiter_if.slave  mst,
  axi_lite_arbiter_if.master slv
);
  localparam int IDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rstate_t;
  typedef enum logic [1:0] {WIDLE, WADDR, WRESP} wstate_t;

  rstate_t rstate_q, rstate_d;
  wstate_t wstate_q, wstate_d;
  idx_t    grant_r_q, grant_r_d, rptr_q, rptr_d;
  idx_t    grant_w_q, grant_w_d, wptr_q, wptr_d;
  logic    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic    aw_hs, w_hs;

  logic [ADDR_W-1:0] ar_addr_arr [NUM_MST];
  logic [ADDR_W-1:0] aw_addr_arr [NUM_MST];
  logic [DATA_W-1:0] w_data_arr  [NUM_MST];
  logic [STRB_W-1:0] w_strb_arr  [NUM_MST];

  // Unpack the per-master buses so the grant can index them directly.
  for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_unpack
    assign ar_addr_arr[gi] = mst.ar_addr[gi*ADDR_W +: ADDR_W];
    assign aw_addr_arr[gi] = mst.aw_addr[gi*ADDR_W +: ADDR_W];
    assign w_data_arr[gi]  = mst.w_data[gi*DATA_W +: DATA_W];
    assign w_strb_arr[gi]  = mst.w_strb[gi*STRB_W +: STRB_W];
  end

  // First requester at or above ptr, wrapping around to index 0.
  function automatic idx_t rr_pick(input logic [NUM_MST-1:0] req, input idx_t ptr);
    idx_t sel;
    idx_t cand;
    logic found;
    int   j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MST; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_MST) j = j - NUM_MST;
      cand = idx_t'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return sel;
  endfunction

  // Master after the one just served becomes the new highest priority.
  function automatic idx_t ptr_after(input idx_t g);
    if (int'(g) == NUM_MST - 1) return '0;
    return g + idx_t'(1);
  endfunction

  // Read FSM: next state, grant/pointer update and channel steering.
  always_comb begin
    rstate_d     = rstate_q;
    grant_r_d    = grant_r_q;
    rptr_d       = rptr_q;
    mst.ar_ready = '0;
    mst.r_valid  = '0;
    mst.r_data   = '0;
    mst.r_resp   = '0;
    slv.ar_valid = 1'b0;
    slv.ar_addr  = '0;
    slv.r_ready  = 1'b0;
    unique case (rstate_q)
      RIDLE: begin
        if (|mst.ar_valid) begin
          grant_r_d = rr_pick(mst.ar_valid, rptr_q);
          rstate_d  = RADDR;
        end
      end
      RADDR: begin
        slv.ar_valid            = mst.ar_valid[grant_r_q];
        slv.ar_addr             = ar_addr_arr[grant_r_q];
        mst.ar_ready[grant_r_q] = slv.ar_ready[0];
        if (mst.ar_valid[grant_r_q] && slv.ar_ready[0]) rstate_d = RDATA;
      end
      RDATA: begin
        mst.r_valid[grant_r_q] = slv.r_valid[0];
        mst.r_data             = slv.r_data;
        mst.r_resp             = slv.r_resp;
        slv.r_ready            = mst.r_ready[grant_r_q];
        if (slv.r_valid[0] && mst.r_ready[grant_r_q]) begin
          rptr_d   = ptr_after(grant_r_q);
          rstate_d = RIDLE;
        end
      end
      default: rstate_d = RIDLE;
    endcase
  end

  // Write FSM: AW and W forward independently, each retired once by its done flag.
  always_comb begin
    wstate_d     = wstate_q;
    grant_w_d    = grant_w_q;
    wptr_d       = wptr_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    mst.aw_ready = '0;
    mst.w_ready  = '0;
    mst.b_valid  = '0;
    mst.b_resp   = '0;
    slv.aw_valid = 1'b0;
    slv.aw_addr  = '0;
    slv.w_valid  = 1'b0;
    slv.w_data   = '0;
    slv.w_strb   = '0;
    slv.b_ready  = 1'b0;
    unique case (wstate_q)
      WIDLE: begin
        if (|mst.aw_valid) begin
          grant_w_d = rr_pick(mst.aw_valid, wptr_q);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = WADDR;
        end
      end
      WADDR: begin
        slv.aw_valid            = mst.aw_valid[grant_w_q] & ~aw_done_q;
        slv.aw_addr             = aw_addr_arr[grant_w_q];
        mst.aw_ready[grant_w_q] = slv.aw_ready[0] & ~aw_done_q;
        slv.w_valid             = mst.w_valid[grant_w_q] & ~w_done_q;
        slv.w_data              = w_data_arr[grant_w_q];
        slv.w_strb              = w_strb_arr[grant_w_q];
        mst.w_ready[grant_w_q]  = slv.w_ready[0] & ~w_done_q;
        aw_hs     = mst.aw_valid[grant_w_q] & ~aw_done_q & slv.aw_ready[0];
        w_hs      = mst.w_valid[grant_w_q] & ~w_done_q & slv.w_ready[0];
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) wstate_d = WRESP;
      end
      WRESP: begin
        mst.b_valid[grant_w_q] = slv.b_valid[0];
        mst.b_resp             = slv.b_resp;
        slv.b_ready            = mst.b_ready[grant_w_q];
        if (slv.b_valid[0] && mst.b_ready[grant_w_q]) begin
          wptr_d   = ptr_after(grant_w_q);
          wstate_d = WIDLE;
        end
      end
      default: wstate_d = WIDLE;
    endcase
  end

  // State, grant and pointer registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q  <= RIDLE;
      wstate_q  <= WIDLE;
      grant_r_q <= '0;
      rptr_q    <= '0;
      grant_w_q <= '0;
      wptr_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      wstate_q  <= wstate_d;
      grant_r_q <= grant_r_d;
      rptr_q    <= rptr_d;
      grant_w_q <= grant_w_d;
      wptr_q    <= wptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with two masters and one slave.
module tb_axi_lite_arbiter;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  axi_lite_arbiter_if #(.N(2), .ADDR_W(32), .DATA_W(32)) mst_if ();
  axi_lite_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) slv_if ();

  axi_lite_arbiter #(.NUM_MST(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .mst (mst_if),
    .slv (slv_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave-side handshake monitor, sampled mid-cycle where everything is stable.
  int          aw_cnt = 0;
  int          w_cnt  = 0;
  logic [31:0] cap_aw_addr, cap_w_data;
  logic [3:0]  cap_w_strb;
  bit          watch_r0, r0_seen;
  always @(negedge clk) begin
    if (slv_if.aw_valid[0] && slv_if.aw_ready[0]) begin
      aw_cnt++;
      cap_aw_addr = slv_if.aw_addr;
    end
    if (slv_if.w_valid[0] && slv_if.w_ready[0]) begin
      w_cnt++;
      cap_w_data = slv_if.w_data;
      cap_w_strb = slv_if.w_strb;
    end
    if (watch_r0 && mst_if.r_valid[0]) r0_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mst_if.ar_valid = '0; mst_if.ar_addr = '0; mst_if.r_ready = '0;
    mst_if.aw_valid = '0; mst_if.aw_addr = '0; mst_if.w_valid = '0;
    mst_if.w_data   = '0; mst_if.w_strb  = '0; mst_if.b_ready = '0;
    slv_if.ar_ready = '0; slv_if.r_valid = '0; slv_if.r_data  = '0; slv_if.r_resp = '0;
    slv_if.aw_ready = '0; slv_if.w_ready = '0; slv_if.b_valid = '0; slv_if.b_resp = '0;
  endtask

  // Plays the slave for one read: waits for AR, accepts it, returns rdata.
  task automatic slave_read(input logic [31:0] rdata, output int gnt, output logic [1:0] rv,
                            output logic [31:0] addr, output bit timeout);
    timeout = 1'b0;
    gnt     = -1;
    rv      = 'x;
    addr    = 'x;
    for (int i = 0; i < 20 && !slv_if.ar_valid[0]; i++) step();
    if (!slv_if.ar_valid[0]) begin
      timeout = 1'b1;
      return;
    end
    slv_if.ar_ready = 1'b1;
    #1;
    case (mst_if.ar_ready)
      2'b01:   gnt = 0;
      2'b10:   gnt = 1;
      default: gnt = -1;
    endcase
    addr = slv_if.ar_addr;
    step();
    slv_if.ar_ready = 1'b0;
    slv_if.r_valid  = 1'b1;
    slv_if.r_data   = rdata;
    slv_if.r_resp   = 2'b00;
    #1;
    rv = mst_if.r_valid;
    step();
    slv_if.r_valid = 1'b0;
    $display("read: master %0d addr %h data %h r_valid %b", gnt, addr, rdata, rv);
  endtask

  task automatic test_reset();
    logic [14:0]  ctl;
    logic [171:0] bus;
    // Inputs are driven active while reset is held; outputs must stay quiet anyway.
    mst_if.ar_valid = 2'b11; mst_if.aw_valid = 2'b11; mst_if.w_valid = 2'b11;
    mst_if.r_ready  = 2'b11; mst_if.b_ready  = 2'b11;
    slv_if.r_valid  = 1'b1;  slv_if.r_data   = 32'hFFFF_FFFF; slv_if.b_valid = 1'b1;
    slv_if.ar_ready = 1'b1;  slv_if.aw_ready = 1'b1; slv_if.w_ready = 1'b1;
    slv_if.r_resp   = 2'b11; slv_if.b_resp   = 2'b11;
    repeat (3) step();
    ctl = {slv_if.ar_valid, slv_if.r_ready, slv_if.aw_valid, slv_if.w_valid, slv_if.b_ready,
           mst_if.ar_ready, mst_if.r_valid, mst_if.aw_ready, mst_if.w_ready, mst_if.b_valid};
    bus = {slv_if.ar_addr, slv_if.aw_addr, slv_if.w_data, slv_if.w_strb,
           mst_if.r_data, mst_if.r_resp, mst_if.b_resp, 32'h0};
    n_cmp++;
    if (ctl !== 15'h0) begin n_err++; $display("FAIL reset_handshake: got %h required 0", ctl); end
    n_cmp++;
    if (bus !== 172'h0) begin n_err++; $display("FAIL reset_buses: got %h required 0", bus); end
    clear_inputs();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    watch_r0 = 1'b1; r0_seen = 1'b0;
    mst_if.ar_valid = 2'b10;
    mst_if.ar_addr[63:32] = 32'h8000_0004;
    mst_if.r_ready = 2'b10;
    #1;
    n_cmp++;
    if (slv_if.ar_valid !== 1'b0) begin n_err++; $display("FAIL sr_arb_latency: slv ar_valid %b required 0", slv_if.ar_valid); end
    step();
    n_cmp++;
    if (slv_if.ar_valid !== 1'b1 || slv_if.ar_addr !== 32'h8000_0004) begin
      n_err++; $display("FAIL sr_ar_fwd: valid %b addr %h required 1 80000004", slv_if.ar_valid, slv_if.ar_addr);
    end
    slv_if.ar_ready = 1'b1;
    #1;
    n_cmp++;
    if (mst_if.ar_ready !== 2'b10) begin n_err++; $display("FAIL sr_ar_ready: got %b required 10", mst_if.ar_ready); end
    step();
    mst_if.ar_valid = 2'b00;
    slv_if.ar_ready = 1'b0;
    slv_if.r_valid = 1'b1; slv_if.r_data = 32'hDEAD_BEEF; slv_if.r_resp = 2'b00;
    #1;
    n_cmp++;
    if (mst_if.r_valid !== 2'b10 || mst_if.r_data !== 32'hDEAD_BEEF || mst_if.r_resp !== 2'b00) begin
      n_err++; $display("FAIL sr_r_route: r_valid %b data %h resp %b required 10 deadbeef 00",
                        mst_if.r_valid, mst_if.r_data, mst_if.r_resp);
    end
    n_cmp++;
    if (slv_if.r_ready !== 1'b1) begin n_err++; $display("FAIL sr_r_ready: got %b required 1", slv_if.r_ready); end
    step();
    slv_if.r_valid = 1'b0;
    $display("read: master 1 addr 80000004 data deadbeef");
    #1;
    n_cmp++;
    if (mst_if.r_valid !== 2'b00) begin n_err++; $display("FAIL sr_r_done: r_valid %b required 00", mst_if.r_valid); end
    step();
    watch_r0 = 1'b0;
    n_cmp++;
    if (r0_seen !== 1'b0) begin n_err++; $display("FAIL sr_r0_quiet: master0 r_valid seen %b required 0", r0_seen); end
  endtask

  task automatic test_contention();
    int          gnt;
    logic [1:0]  rv;
    logic [31:0] addr;
    bit          to;
    int          exp_g [4] = '{0, 1, 0, 1};
    mst_if.ar_valid = 2'b11;
    mst_if.ar_addr  = {32'h0000_2000, 32'h0000_1000};
    mst_if.r_ready  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      slave_read(32'h100 + 32'(t), gnt, rv, addr, to);
      n_cmp++;
      if (to || gnt !== exp_g[t]) begin
        n_err++; $display("FAIL rr_grant%0d: granted %0d (timeout %0d) required %0d", t, gnt, to, exp_g[t]);
      end
      n_cmp++;
      if (rv !== (exp_g[t] == 0 ? 2'b01 : 2'b10) ||
          addr !== (exp_g[t] == 0 ? 32'h0000_1000 : 32'h0000_2000)) begin
        n_err++; $display("FAIL rr_route%0d: r_valid %b addr %h for master %0d", t, rv, addr, exp_g[t]);
      end
    end
    mst_if.ar_valid = 2'b00;
    step();
  endtask

  task automatic test_write_order();
    int aw_base, w_base;
    aw_base = aw_cnt; w_base = w_cnt;
    mst_if.w_valid = 2'b01; mst_if.w_data[31:0] = 32'h1234_5678; mst_if.w_strb[3:0] = 4'hF;
    mst_if.b_ready = 2'b01;
    slv_if.w_ready = 1'b1; slv_if.aw_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (slv_if.w_valid !== 1'b0) begin n_err++; $display("FAIL wo_w_alone%0d: slv w_valid %b required 0", c, slv_if.w_valid); end
    end
    mst_if.aw_valid = 2'b01; mst_if.aw_addr[31:0] = 32'h0000_0040;
    step();
    n_cmp++;
    if ({slv_if.aw_valid, slv_if.w_valid, mst_if.w_ready} !== 4'b1101) begin
      n_err++; $display("FAIL wo_fwd: aw_v w_v w_ready %b%b%b required 1101", slv_if.aw_valid, slv_if.w_valid, mst_if.w_ready);
    end
    step();
    n_cmp++;
    if ({slv_if.aw_valid, slv_if.w_valid, mst_if.w_ready} !== 4'b1000) begin
      n_err++; $display("FAIL wo_w_retired: aw_v w_v w_ready %b%b%b required 1000", slv_if.aw_valid, slv_if.w_valid, mst_if.w_ready);
    end
    slv_if.aw_ready = 1'b1;
    step();
    mst_if.aw_valid = 2'b00; mst_if.w_valid = 2'b00;
    slv_if.aw_ready = 1'b0; slv_if.w_ready = 1'b0;
    slv_if.b_valid = 1'b1; slv_if.b_resp = 2'b00;
    #1;
    n_cmp++;
    if (mst_if.b_valid !== 2'b01) begin n_err++; $display("FAIL wo_b_route: b_valid %b required 01", mst_if.b_valid); end
    step();
    slv_if.b_valid = 1'b0;
    step();
    $display("write: master 0 addr %h data %h strb %h", cap_aw_addr, cap_w_data, cap_w_strb);
    n_cmp++;
    if (aw_cnt - aw_base !== 1 || w_cnt - w_base !== 1) begin
      n_err++; $display("FAIL wo_once: aw %0d w %0d handshakes required 1 1", aw_cnt - aw_base, w_cnt - w_base);
    end
    n_cmp++;
    if (cap_aw_addr !== 32'h40 || cap_w_data !== 32'h1234_5678 || cap_w_strb !== 4'hF) begin
      n_err++; $display("FAIL wo_payload: addr %h data %h strb %h required 00000040 12345678 f", cap_aw_addr, cap_w_data, cap_w_strb);
    end
  endtask

  task automatic test_same_cycle();
    int aw_base, w_base;
    aw_base = aw_cnt; w_base = w_cnt;
    mst_if.aw_valid = 2'b11; mst_if.w_valid = 2'b11;
    mst_if.aw_addr  = {32'h2000_0008, 32'h1000_0000};
    mst_if.w_data   = {32'hA5A5_0001, 32'h0};
    mst_if.w_strb   = {4'h3, 4'h0};
    mst_if.b_ready  = 2'b11;
    slv_if.aw_ready = 1'b1; slv_if.w_ready = 1'b1;
    step();
    // Previous write went to master 0, so master 1 must win now.
    n_cmp++;
    if (mst_if.aw_ready !== 2'b10 || mst_if.w_ready !== 2'b10 || slv_if.aw_addr !== 32'h2000_0008) begin
      n_err++; $display("FAIL sc_grant: aw_ready %b w_ready %b addr %h required 10 10 20000008",
                        mst_if.aw_ready, mst_if.w_ready, slv_if.aw_addr);
    end
    step();
    n_cmp++;
    if ({slv_if.aw_valid, slv_if.w_valid, slv_if.b_ready} !== 3'b001) begin
      n_err++; $display("FAIL sc_wresp: aw_v w_v b_ready %b%b%b required 001", slv_if.aw_valid, slv_if.w_valid, slv_if.b_ready);
    end
    mst_if.aw_valid = 2'b00; mst_if.w_valid = 2'b00;
    slv_if.b_valid = 1'b1; slv_if.b_resp = 2'b01;
    #1;
    n_cmp++;
    if (mst_if.b_valid !== 2'b10 || mst_if.b_resp !== 2'b01) begin
      n_err++; $display("FAIL sc_b_route: b_valid %b resp %b required 10 01", mst_if.b_valid, mst_if.b_resp);
    end
    step();
    slv_if.b_valid = 1'b0; slv_if.aw_ready = 1'b0; slv_if.w_ready = 1'b0;
    step();
    $display("write: master 1 addr %h data %h strb %h", cap_aw_addr, cap_w_data, cap_w_strb);
    n_cmp++;
    if (aw_cnt - aw_base !== 1 || w_cnt - w_base !== 1 || cap_w_data !== 32'hA5A5_0001 || cap_w_strb !== 4'h3) begin
      n_err++; $display("FAIL sc_once: aw %0d w %0d data %h strb %h required 1 1 a5a50001 3",
                        aw_cnt - aw_base, w_cnt - w_base, cap_w_data, cap_w_strb);
    end
  endtask

  task automatic test_concurrent();
    mst_if.ar_valid = 2'b01; mst_if.ar_addr[31:0] = 32'h0000_0100;
    mst_if.aw_valid = 2'b10; mst_if.aw_addr[63:32] = 32'h0000_0200;
    mst_if.w_valid  = 2'b10; mst_if.w_data[63:32] = 32'hCAFE_F00D; mst_if.w_strb[7:4] = 4'hF;
    mst_if.r_ready  = 2'b11; mst_if.b_ready = 2'b11;
    slv_if.ar_ready = 1'b1; slv_if.aw_ready = 1'b1; slv_if.w_ready = 1'b1;
    step();
    n_cmp++;
    if (mst_if.ar_ready !== 2'b01 || mst_if.aw_ready !== 2'b10 ||
        slv_if.ar_addr !== 32'h100 || slv_if.aw_addr !== 32'h200) begin
      n_err++; $display("FAIL cc_grants: ar_ready %b aw_ready %b ar_addr %h aw_addr %h required 01 10 100 200",
                        mst_if.ar_ready, mst_if.aw_ready, slv_if.ar_addr, slv_if.aw_addr);
    end
    step();
    mst_if.ar_valid = 2'b00; mst_if.aw_valid = 2'b00; mst_if.w_valid = 2'b00;
    slv_if.ar_ready = 1'b0; slv_if.aw_ready = 1'b0; slv_if.w_ready = 1'b0;
    slv_if.b_valid = 1'b1; slv_if.b_resp = 2'b00;
    #1;
    n_cmp++;
    if (mst_if.b_valid !== 2'b10 || mst_if.r_valid !== 2'b00) begin
      n_err++; $display("FAIL cc_b_route: b_valid %b r_valid %b required 10 00", mst_if.b_valid, mst_if.r_valid);
    end
    step();
    slv_if.b_valid = 1'b0;
    $display("write: master 1 addr 00000200 data %h", cap_w_data);
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (mst_if.r_valid !== 2'b00) begin n_err++; $display("FAIL cc_r_stall%0d: r_valid %b required 00", c, mst_if.r_valid); end
    end
    slv_if.r_valid = 1'b1; slv_if.r_data = 32'h55AA_55AA; slv_if.r_resp = 2'b10;
    #1;
    n_cmp++;
    if (mst_if.r_valid !== 2'b01 || mst_if.r_data !== 32'h55AA_55AA || mst_if.r_resp !== 2'b10) begin
      n_err++; $display("FAIL cc_r_route: r_valid %b data %h resp %b required 01 55aa55aa 10",
                        mst_if.r_valid, mst_if.r_data, mst_if.r_resp);
    end
    step();
    slv_if.r_valid = 1'b0;
    $display("read: master 0 addr 00000100 data 55aa55aa");
    n_cmp++;
    if (cap_w_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL cc_w_payload: got %h required cafef00d", cap_w_data); end
  endtask

  task automatic test_async_reset();
    int          gnt;
    logic [1:0]  rv;
    logic [31:0] addr;
    bit          to;
    mst_if.ar_valid = 2'b01; mst_if.ar_addr[31:0] = 32'h0000_0400; mst_if.r_ready = 2'b11;
    step();
    slv_if.ar_ready = 1'b1;
    step();
    mst_if.ar_valid = 2'b00; slv_if.ar_ready = 1'b0;
    slv_if.r_valid = 1'b1; slv_if.r_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (mst_if.r_valid !== 2'b01) begin n_err++; $display("FAIL ar_in_rdata: r_valid %b required 01", mst_if.r_valid); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mst_if.r_valid !== 2'b00 || mst_if.r_data !== 32'h0 || slv_if.r_ready !== 1'b0) begin
      n_err++; $display("FAIL ar_immediate: r_valid %b data %h r_ready %b required 00 0 0",
                        mst_if.r_valid, mst_if.r_data, slv_if.r_ready);
    end
    slv_if.r_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    // Pointer was 1 before reset; a cleared pointer favours master 0 again.
    mst_if.ar_valid = 2'b11;
    mst_if.ar_addr  = {32'h0000_0300, 32'h0000_0500};
    slave_read(32'h1111_2222, gnt, rv, addr, to);
    n_cmp++;
    if (to || gnt !== 0 || rv !== 2'b01) begin
      n_err++; $display("FAIL ar_ptr_cleared: granted %0d r_valid %b timeout %0d required 0 01 0", gnt, rv, to);
    end
    mst_if.ar_valid = 2'b10;
    slave_read(32'h0BAD_CAFE, gnt, rv, addr, to);
    n_cmp++;
    if (to || gnt !== 1 || rv !== 2'b10 || addr !== 32'h300) begin
      n_err++; $display("FAIL ar_after_reset: granted %0d r_valid %b addr %h timeout %0d required 1 10 300 0", gnt, rv, addr, to);
    end
    mst_if.ar_valid = 2'b00;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    watch_r0 = 1'b0;
    r0_seen  = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_write_order();
    test_same_cycle();
    test_concurrent();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4-Lite arbiter that replaces the fixed single-master core-to-RAM wiring.
- Lets several requesters (IFU, LSU, future DMA) share one AXI-Lite slave such as the RAM model or the UART/CLINT bridge.
- Read and write channels are arbitrated independently, each round-robin, with one outstanding transaction per channel.
- Sits between the core's memory requesters and the system slave.

Parameters:
- NUM_MST, 2, number of upstream masters (≥1). Index 0 is highest priority at reset.
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Strobe width is DATA_W/8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mst_ar_valid_i / mst_ar_ready_o  in/out  NUM_MST  per-master read address handshake.
- mst_ar_addr_i  in  NUM_MST*ADDR_W  packed read addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- mst_r_valid_o / mst_r_ready_i  out/in  NUM_MST  per-master read data handshake.
- mst_r_data_o  out  DATA_W  read data, shared by all masters. Qualify with own r_valid.
- mst_r_resp_o  out  2  read response, shared.
- mst_aw_valid_i / mst_aw_ready_o  in/out  NUM_MST  write address handshake.
- mst_aw_addr_i  in  NUM_MST*ADDR_W  packed write addresses.
- mst_w_valid_i / mst_w_ready_o  in/out  NUM_MST  write data handshake.
- mst_w_data_i  in  NUM_MST*DATA_W  packed write data.
- mst_w_strb_i  in  NUM_MST*DATA_W/8  packed write strobes.
- mst_b_valid_o / mst_b_ready_i  out/in  NUM_MST  write response handshake.
- mst_b_resp_o  out  2  write response, shared.
- slv_ar_valid_o, slv_ar_addr_o[ADDR_W], slv_ar_ready_i  downstream read address channel.
- slv_r_valid_i, slv_r_data_i[DATA_W], slv_r_resp_i[2], slv_r_ready_o  downstream read data channel.
- slv_aw_valid_o, slv_aw_addr_o, slv_aw_ready_i  downstream write address channel.
- slv_w_valid_o, slv_w_data_o, slv_w_strb_o, slv_w_ready_i  downstream write data channel.
- slv_b_valid_i, slv_b_resp_i, slv_b_ready_o  downstream write response channel.

Behaviour:
- Reset (rst=0, asynchronous):
  - Both FSMs go to IDLE and both round-robin pointers go to 0.
  - All valid/ready outputs are 0; address, data and strobe outputs are 0.
  - Reset mid-transaction abandons it; the slave is not drained.
- Read FSM, states RIDLE, RADDR, RDATA:
  - RIDLE: if any mst_ar_valid_i is set, register grant_r = first set bit searching from rptr upward with wrap, then go to RADDR. This costs 1 cycle of arbitration latency. No outputs are asserted in RIDLE.
  - RADDR: slv_ar_valid_o = mst_ar_valid_i[grant_r]; slv_ar_addr_o = granted address; mst_ar_ready_o[grant_r] = slv_ar_ready_i; all other ready bits are 0. On slv AR handshake go to RDATA.
  - RDATA: mst_r_valid_o[grant_r] = slv_r_valid_i; data and resp pass through combinationally; slv_r_ready_o = mst_r_ready_i[grant_r]. On R handshake, rptr = (grant_r+1) mod NUM_MST and go to RIDLE.
  - Non-granted masters always see ready=0 and valid=0.
  - A granted master that drops ar_valid in RADDR (a protocol violation) leaves the FSM holding in RADDR; no recovery is required.
- Write FSM, states WIDLE, WADDR, WRESP:
  - WIDLE: arbitration uses only mst_aw_valid_i. A w_valid without aw_valid does not request. Grant rule is the same as for reads, using wptr. Clear aw_done and w_done, then go to WADDR.
  - WADDR: the AW and W channels forward independently for grant_w. slv_aw_valid_o = mst_aw_valid_i[grant_w] & ~aw_done; slv_w_valid_o = mst_w_valid_i[grant_w] & ~w_done. Each handshake sets its done flag.
  - WADDR exit: go to WRESP when both are complete, counting handshakes in the current cycle. AW and W in the same cycle leads straight to WRESP the next cycle.
  - WRESP: B passes through to grant_w. On B handshake, wptr = (grant_w+1) mod NUM_MST and go to WIDLE.
- Read and write FSMs are fully independent. The same master may hold both grants simultaneously.
- Slave-side signals are combinational from the registered grant. There are no data buffers, so RADDR→slave and RDATA→master add 0 cycles.
- NUM_MST=1 degenerates to a pass-through with 1 cycle of arbitration latency per transaction.
- Pointer wrap: a grant to NUM_MST-1 sets the pointer to 0.

Test Plan:
- Single read: NUM_MST=2, master1 reads 0x8000_0004, slave returns 0xDEADBEEF with resp=0 → master1 sees r_valid with data 0xDEADBEEF; mst_r_valid_o[0] stays 0 throughout; rptr becomes 0.
- Contention fairness: both masters hold ar_valid continuously for 4 transactions → grants alternate 0,1,0,1 and no master is starved.
- Write ordering: master0 presents W two cycles before AW, with wdata 0x1234_5678 and strb 0xF → slave receives both exactly once; one B goes to master0 only; wptr becomes 1.
- Same-cycle AW+W: with slave aw_ready=w_ready=1 → state is WRESP on the next cycle with no duplicate valids.
- Concurrent read and write: master0 reads while master1 writes, with slave stalls on r_valid of 3 cycles → both complete, and responses route to the correct masters.
- Async reset: assert rst=0 in RDATA between clock edges → all outputs go to 0 immediately; after release, a new read from master1 completes normally.
